// File: rtl/sound_request_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sound_request_arbiter_if : requester / audio_playout bus for the arbiter   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sound_request_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int SOUND_IDX_BITS = 1
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ*SOUND_IDX_BITS-1:0] req_idx;
  logic                              play_busy;
  logic                              play_sound;
  logic [SOUND_IDX_BITS-1:0]         sound_idx;
  logic [GW-1:0]                     grant_id;
  logic                              active;
  logic [NUM_REQ-1:0]                pending;
  logic                              overwrite_strobe;
  logic                              timeout_strobe;

  modport slave (
    input  req, req_idx, play_busy,
    output play_sound, sound_idx, grant_id, active, pending,
           overwrite_strobe, timeout_strobe
  );

  modport master (
    output req, req_idx, play_busy,
    input  play_sound, sound_idx, grant_id, active, pending,
           overwrite_strobe, timeout_strobe
  );
endinterface
`default_nettype wire

// File: rtl/sound_request_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sound_request_arbiter : shares audio_playout between game-event requesters |
// | SOUND_ARB_RR_EN selects round-robin instead of fixed-priority arbitration. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sound_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SOUND_IDX_BITS = 1,
  parameter int ACK_TIMEOUT    = 64,
  parameter int GAP_CYCLES     = 0
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  sound_request_arbiter_if.slave bus
);
  localparam int GW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] C_ACK_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_PLAYING    = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  state_t                                 state_q, state_d;
  logic [NUM_REQ-1:0]                     pending_q, pending_d;
  logic [NUM_REQ-1:0][SOUND_IDX_BITS-1:0] idx_q, idx_d;
  logic [SOUND_IDX_BITS-1:0]              sound_idx_q, sound_idx_d;
  logic [GW-1:0]                          grant_id_q, grant_id_d;
  logic                                   active_q, active_d;
  logic                                   ovw_q, ovw_d;
  logic                                   to_q, to_d;
  logic [CW-1:0]                          cnt_q, cnt_d;

  logic                                   win_vld;
  logic [GW-1:0]                          win_id;
  logic                                   grant;
  logic [NUM_REQ-1:0]                     grant_vec;

`ifdef SOUND_ARB_RR_EN
  logic [GW-1:0] ptr_q, ptr_d;
  int            rr_j;

  // Descending scan so the slot nearest the pointer is the last to win.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    rr_j    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_j = (int'(ptr_q) + k) % NUM_REQ;
      if (pending_q[rr_j]) begin
        win_vld = 1'b1;
        win_id  = GW'(rr_j);
      end
    end
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = GW'((int'(win_id) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        win_vld = 1'b1;
        win_id  = GW'(k);
      end
    end
  end
`endif

  assign grant     = (state_q == S_IDLE) && win_vld && !bus.play_busy;
  assign grant_vec = grant ? (NUM_REQ'(1) << win_id) : '0;

  // A request landing on the slot being granted re-arms it; the grant takes the old index.
  always_comb begin
    pending_d = (pending_q & ~grant_vec) | bus.req;
    idx_d     = idx_q;
    ovw_d     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i]) begin
        idx_d[i] = bus.req_idx[i*SOUND_IDX_BITS +: SOUND_IDX_BITS];
        if (pending_q[i] && !grant_vec[i]) begin
          ovw_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sound_idx_d = sound_idx_q;
    grant_id_d  = grant_id_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    to_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          sound_idx_d = idx_q[win_id];
          grant_id_d  = win_id;
          active_d    = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (bus.play_busy) begin
          state_d = S_PLAYING;
        end else if (cnt_q == C_ACK_LAST) begin
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PLAYING: begin
        if (!bus.play_busy) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == C_GAP_LAST) begin
          active_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      idx_q       <= '0;
      sound_idx_q <= '0;
      grant_id_q  <= '0;
      active_q    <= 1'b0;
      ovw_q       <= 1'b0;
      to_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      sound_idx_q <= sound_idx_d;
      grant_id_q  <= grant_id_d;
      active_q    <= active_d;
      ovw_q       <= ovw_d;
      to_q        <= to_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.play_sound       = (state_q == S_ISSUE);
  assign bus.sound_idx        = sound_idx_q;
  assign bus.grant_id         = grant_id_q;
  assign bus.active           = active_q;
  assign bus.pending          = pending_q;
  assign bus.overwrite_strobe = ovw_q;
  assign bus.timeout_strobe   = to_q;
endmodule
`default_nettype wire

// File: tb/tb_sound_request_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sound_request_arbiter : directed bench, NUM_REQ=4, ACK_TIMEOUT=8, GAP=5 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sound_request_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   g, ix, bad;

  sound_request_arbiter_if #(.NUM_REQ(4), .SOUND_IDX_BITS(2)) bus ();

  sound_request_arbiter #(
    .NUM_REQ(4), .SOUND_IDX_BITS(2), .ACK_TIMEOUT(8), .GAP_CYCLES(5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef SOUND_ARB_RR_EN
  int exp_g[4] = '{0, 1, 3, 0};
`else
  int exp_g[4] = '{0, 0, 0, 1};
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idx(input int slot, input logic [1:0] v);
    bus.req_idx[slot*2 +: 2] = v;
  endtask

  // Waits for the next issue, records it, then plays the sound and runs out the gap.
  task automatic serve(input logic [3:0] rq, output int gid, output int sid);
    int n = 0;
    while (bus.play_sound !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      gid = -1;
      sid = -1;
      return;
    end
    gid = int'(bus.grant_id);
    sid = int'(bus.sound_idx);
    bus.play_busy = 1'b1;
    bus.req       = rq;
    tick();
    bus.req = '0;
    tick();
    bus.play_busy = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.req       = '0;
    bus.req_idx   = '0;
    bus.play_busy = 1'b0;
    repeat (3) tick();
    chk("rst_play", bus.play_sound, 0);
    chk("rst_idx", bus.sound_idx, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_active", bus.active, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_strobes", {bus.overwrite_strobe, bus.timeout_strobe}, 0);
    reset_n = 1'b1;
    tick();

    // Single request on slot 2
    bus.req = 4'b0100;
    set_idx(2, 2'd1);
    tick();
    bus.req = '0;
    chk("t1_pending", bus.pending, 4'b0100);
    chk("t1_no_play_yet", bus.play_sound, 0);
    tick();
    chk("t1_play", bus.play_sound, 1);
    chk("t1_idx", bus.sound_idx, 1);
    chk("t1_grant", bus.grant_id, 2);
    chk("t1_active", bus.active, 1);
    chk("t1_pending_clr", bus.pending, 0);
    tick();
    chk("t1_play_one_cycle", bus.play_sound, 0);
    tick();
    bus.play_busy = 1'b1;
    repeat (10) tick();
    chk("t1_active_playing", bus.active, 1);
    chk("t1_no_timeout", bus.timeout_strobe, 0);
    bus.play_busy = 1'b0;
    repeat (5) tick();
    chk("t1_active_gap_end", bus.active, 1);
    tick();
    chk("t1_active_off", bus.active, 0);

    // Two pending: gap spacing, then ack timeout on the second sound
    bus.req = 4'b0011;
    set_idx(0, 2'd2);
    set_idx(1, 2'd3);
    tick();
    bus.req = '0;
    chk("t2_pending", bus.pending, 4'b0011);
    tick();
    chk("t2_grant0", bus.grant_id, 0);
    chk("t2_idx0", bus.sound_idx, 2);
    chk("t2_pending_after", bus.pending, 4'b0010);
    bus.play_busy = 1'b1;
    tick();
    tick();
    bus.play_busy = 1'b0;
    bad = 0;
    repeat (6) begin
      tick();
      bad += int'(bus.play_sound);
    end
    chk("t2_gap_quiet", bad, 0);
    tick();
    chk("t2_play_at_gap_plus7", bus.play_sound, 1);
    chk("t2_grant1", bus.grant_id, 1);
    chk("t2_idx1", bus.sound_idx, 3);
    tick();
    bus.req = 4'b1000;
    set_idx(3, 2'd1);
    tick();
    bus.req = '0;
    chk("t3_pending_latched", bus.pending, 4'b1000);
    bad = 0;
    repeat (6) begin
      tick();
      bad += int'(bus.timeout_strobe);
    end
    chk("t3_timeout_early", bad, 0);
    tick();
    chk("t3_timeout_pulse", bus.timeout_strobe, 1);
    chk("t3_active_in_gap", bus.active, 1);
    tick();
    chk("t3_timeout_one_cycle", bus.timeout_strobe, 0);
    serve(4'b0000, g, ix);
    chk("t3_next_grant", g, 3);
    chk("t3_next_idx", ix, 1);

    // Simultaneous requests with repeated slot-0 requests
    bus.req = 4'b1011;
    set_idx(0, 2'd0);
    set_idx(1, 2'd1);
    set_idx(3, 2'd2);
    tick();
    bus.req = '0;
    chk("t4_pending", bus.pending, 4'b1011);
    for (int k = 0; k < 4; k++) begin
      serve((k < 2) ? 4'b0001 : 4'b0000, g, ix);
      chk($sformatf("t4_order%0d", k), g, exp_g[k]);
    end
`ifndef SOUND_ARB_RR_EN
    serve(4'b0000, g, ix);
    chk("t4_order_last", g, 3);
`endif
    chk("t4_drained", bus.pending, 0);

    // Overwrite while the engine is externally busy
    bus.play_busy = 1'b1;
    tick();
    bus.req = 4'b0010;
    set_idx(1, 2'd0);
    tick();
    chk("t5_no_ovw_first", bus.overwrite_strobe, 0);
    set_idx(1, 2'd1);
    tick();
    bus.req = '0;
    chk("t5_ovw_pulse", bus.overwrite_strobe, 1);
    chk("t5_pending", bus.pending, 4'b0010);
    chk("t5_held_by_busy", bus.play_sound, 0);
    tick();
    chk("t5_ovw_one_cycle", bus.overwrite_strobe, 0);
    bus.play_busy = 1'b0;
    serve(4'b0000, g, ix);
    chk("t5_grant", g, 1);
    chk("t5_latest_idx", ix, 1);
    bad = 0;
    repeat (10) begin
      tick();
      bad += int'(bus.play_sound);
    end
    chk("t5_single_play", bad, 0);
    chk("t5_pending_clr", bus.pending, 0);

    // Request on the slot being granted in the same cycle
    bus.play_busy = 1'b1;
    bus.req = 4'b0100;
    set_idx(2, 2'd2);
    tick();
    bus.req = '0;
    tick();
    set_idx(2, 2'd3);
    bus.req = 4'b0100;
    bus.play_busy = 1'b0;
    tick();
    bus.req = '0;
    chk("t6_play", bus.play_sound, 1);
    chk("t6_old_idx", bus.sound_idx, 2);
    chk("t6_still_pending", bus.pending, 4'b0100);
    chk("t6_no_ovw", bus.overwrite_strobe, 0);
    serve(4'b0000, g, ix);
    serve(4'b0000, g, ix);
    chk("t6_second_grant", g, 2);
    chk("t6_new_idx", ix, 3);

    // Asynchronous reset while playing with requests pending
    set_idx(0, 2'd3);
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    tick();
    bus.play_busy = 1'b1;
    tick();
    tick();
    bus.req = 4'b0110;
    tick();
    bus.req = '0;
    chk("t7_pending_pre", bus.pending, 4'b0110);
    chk("t7_active_pre", bus.active, 1);
    chk("t7_idx_pre", bus.sound_idx, 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_async_pending", bus.pending, 0);
    chk("t7_async_active", bus.active, 0);
    chk("t7_async_idx", bus.sound_idx, 0);
    chk("t7_async_play", bus.play_sound, 0);
    tick();
    reset_n = 1'b1;
    bus.play_busy = 1'b0;
    bad = 0;
    repeat (15) begin
      tick();
      bad += int'(bus.play_sound);
    end
    chk("t7_no_play_after_reset", bad, 0);
    chk("t7_pending_after", bus.pending, 0);
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    tick();
    chk("t7_new_req_play", bus.play_sound, 1);
    chk("t7_new_req_grant", bus.grant_id, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sound_request_arbiter.md
Name: sound_request_arbiter

Overview:
Shares the single audio_playout engine between several game-event requesters (paddle hit, wall bounce, score, etc.) in the 49.5 MHz game clock domain. The block latches requests and picks one winner. It issues a one-cycle play_sound/sound_idx command to audio_playout, then tracks the engine's busy signal until the sound completes. It enforces an ack timeout and a minimum inter-sound gap before granting the next sound.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
SOUND_IDX_BITS, 1, width of sound index (matches audio_playout)
ACK_TIMEOUT, 64, cycles to wait for play_busy to rise after issue (>=1)
GAP_CYCLES, 0, idle cycles forced between end of one sound and next issue (0 = none)

Ports:
clk  in  1  game clock (49.5 MHz domain)
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester single-cycle request strobe
req_idx  in  NUM_REQ x SOUND_IDX_BITS  sound index, sampled when req[i]=1
play_busy  in  1  audio_playout is playing a sound
play_sound  out  1  one-cycle start command to audio_playout
sound_idx  out  SOUND_IDX_BITS  sound to play, valid while play_sound=1 and held until next issue
grant_id  out  $clog2(NUM_REQ)  requester owning the current/last sound
active  out  1  high from issue until end of GAP
pending  out  NUM_REQ  latched, not-yet-served requests
overwrite_strobe  out  1  one-cycle pulse: a req hit an already-pending slot
timeout_strobe  out  1  one-cycle pulse: play_busy never rose within ACK_TIMEOUT

Behaviour:
- Reset (async assert, sync release is upstream's job): state=IDLE; pending=0; all stored idx=0; play_sound=0; sound_idx=0; grant_id=0; active=0; both strobes=0; counters=0.
- Capture: req[i]=1 at cycle N -> pending[i]=1, idx_q[i]=req_idx[i] at N+1.
  - If pending[i] was already 1 and slot i is not granted at N: overwrite idx_q[i] (latest wins) and pulse overwrite_strobe at N+1.
  - If req[i] arrives the same cycle slot i is granted: the grant consumes the old idx. The new request remains pending. No overwrite strobe.
- FSM states: IDLE, ISSUE, WAIT_START, PLAYING, GAP.
  - IDLE: if |pending and !play_busy, select winner w, load sound_idx=idx_q[w] and grant_id=w, clear pending[w], go ISSUE, set active=1. If play_busy=1 (engine externally busy), stay in IDLE.
  - ISSUE: play_sound=1 for exactly this one cycle. Clear the timeout counter. Go WAIT_START.
  - WAIT_START: if play_busy=1, go PLAYING. Otherwise increment the counter. When counter reaches ACK_TIMEOUT-1, pulse timeout_strobe and go GAP.
  - PLAYING: when play_busy=0, go GAP.
  - GAP: count GAP_CYCLES cycles, then go IDLE with active=0. GAP_CYCLES=0: GAP lasts one cycle.
- Latency: req at N with idle arbiter and engine -> pending at N+1 -> play_sound high at N+2.
- Arbitration (default): fixed priority, lowest index wins.
- Simultaneous requests on multiple slots are all captured; they are served one per sound in arbitration order.
- Requests arriving during ISSUE/WAIT_START/PLAYING/GAP are only latched; there is no preemption.
- Counters are sized $clog2(max(ACK_TIMEOUT,GAP_CYCLES)+1) bits and never wrap.

Optional Feature:
SOUND_ARB_RR_EN
- Defined: round-robin arbitration. A pointer holds last grant_id+1 (mod NUM_REQ), reset 0. The search starts at the pointer and wraps. The pointer updates on every grant.
- Undefined: fixed priority as above; no pointer logic is synthesized.

Test Plan:
- Single request: NUM_REQ=4, req[2]=1 with idx=1 at cycle 10, play_busy rises at 14 and falls at 100 -> play_sound=1 only at cycle 12, sound_idx=1, grant_id=2, active 12..101, pending=0 after cycle 12.
- Simultaneous: req=4'b1011 in one cycle, engine completes each sound -> grants in order 0,1,3 (fixed priority), or 0,1,3 then fairness check with RR_EN via repeated req[0] interleaving: with macro, 0,1,3,0; without, 0,0,...
- Overwrite: req[1] idx=0, then req[1] idx=1 while pending and engine busy -> overwrite_strobe one pulse, served sound_idx=1, exactly one play_sound.
- Timeout: ACK_TIMEOUT=8, play_busy held 0 -> timeout_strobe one cycle at issue+9, arbiter returns to IDLE and serves next pending.
- Gap: GAP_CYCLES=5, two pending requests -> next play_sound exactly 7 cycles after play_busy falls.
- Reset mid-PLAYING: drop reset_n with pending=4'b0110 -> all outputs 0 immediately (async); no play_sound after release until new req.
